// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: hazard, halt-drain and IN-handshake control for the 5-stage MIPS pipeline
module pipeline_sequencer #(
  parameter int REG_AW       = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_halt,
  input  logic              id_in,
  input  logic              id_jump,
  input  logic              id_jump_r,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              in_valid,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              in_ack,
  output logic              halted,
  output logic [15:0]       stall_count
);
  typedef enum logic [1:0] {RUN, IN_WAIT, DRAIN, HALTED} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        halted_q, halted_d;
  logic [15:0] stall_q, stall_d;
  logic        load_use, active;
  logic        pc_w, ifid_w, ifid_f, idex_f, ack;
  assign load_use = ex_mem_read & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  assign active   = (state_q == RUN) | (state_q == IN_WAIT);
  // state, drain counter, halted flag and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
    end
  end
  // next state: branch squash beats load-use beats HALT beats IN wait; drain counts down to HALTED
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (active) begin
      if (ex_branch_taken)
        state_d = RUN;
      else if (load_use)
        state_d = state_q;
      else if (id_halt && state_q == RUN) begin
        state_d = DRAIN;
        cnt_d   = 3'(DRAIN_CYCLES - 1);
      end else
        state_d = (id_in && !in_valid) ? IN_WAIT : RUN;
    end else if (state_q == DRAIN) begin
      cnt_d   = cnt_q - 3'd1;
      state_d = (cnt_q == 3'd0) ? HALTED : DRAIN;
    end
    halted_d = (state_d == HALTED);
    stall_d  = (!pc_w && state_q != HALTED && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  // outputs: default is a stall with a bubble into EX, which also covers DRAIN and HALTED
  always_comb begin
    pc_w   = 1'b0;
    ifid_w = 1'b0;
    ifid_f = 1'b0;
    idex_f = 1'b1;
    ack    = 1'b0;
    if (active) begin
      if (ex_branch_taken) begin
        pc_w   = 1'b1;
        ifid_w = 1'b1;
        ifid_f = 1'b1;
      end else if (!(load_use || (id_halt && state_q == RUN) || (id_in && !in_valid))) begin
        pc_w   = 1'b1;
        ifid_w = 1'b1;
        idex_f = 1'b0;
        ack    = id_in;
        ifid_f = !id_in & (id_jump | id_jump_r);
      end
    end
  end
  assign pc_write    = rst_n & pc_w;
  assign ifid_write  = rst_n & ifid_w;
  assign ifid_flush  = !rst_n | ifid_f;
  assign idex_flush  = !rst_n | idex_f;
  assign in_ack      = rst_n & ack;
  assign halted      = halted_q;
  assign stall_count = stall_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed checks of hazards, IN handshake, halt drain and stall saturation
module tb_pipeline_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_halt = 0, id_in = 0, id_jump = 0, id_jump_r = 0, id_uses_rt = 0;
  logic [2:0] id_rs = 0, id_rt = 0, ex_rd = 0;
  logic ex_mem_read = 0, ex_branch_taken = 0, in_valid = 0;
  logic pc_write, ifid_write, ifid_flush, idex_flush, in_ack, halted;
  logic [15:0] stall_count;
  int checks = 0;
  int errors = 0;
  pipeline_sequencer #(.REG_AW(3), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_halt(id_halt), .id_in(id_in), .id_jump(id_jump),
    .id_jump_r(id_jump_r), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .in_valid(in_valid), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .in_ack(in_ack),
    .halted(halted), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial begin
    #1;
    chk("rst_pc", pc_write, 0);
    chk("rst_ifid_w", ifid_write, 0);
    chk("rst_ifid_f", ifid_flush, 1);
    chk("rst_idex_f", idex_flush, 1);
    chk("rst_ack", in_ack, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall_count, 0);
    tick(); rst_n = 1; #1;
    chk("idle_pc", pc_write, 1);
    chk("idle_ifid_f", ifid_flush, 0);
    chk("idle_idex_f", idex_flush, 0);
    tick(); ex_mem_read = 1; ex_rd = 2; id_rs = 2; #1;
    chk("lu_rs_pc", pc_write, 0);
    chk("lu_rs_ifid_w", ifid_write, 0);
    chk("lu_rs_idex_f", idex_flush, 1);
    tick(); ex_mem_read = 0; #1;
    chk("lu_after_pc", pc_write, 1);
    chk("lu_after_stall", stall_count, 1);
    tick(); ex_mem_read = 1; id_rs = 5; id_rt = 2; id_uses_rt = 1; #1;
    chk("lu_rt_pc", pc_write, 0);
    tick(); id_uses_rt = 0; #1;
    chk("lu_rt_unused_pc", pc_write, 1);
    chk("lu_rt_stall", stall_count, 2);
    tick(); ex_mem_read = 0; id_in = 1; in_valid = 0; #1;
    chk("in_wait_pc", pc_write, 0);
    chk("in_wait_ack", in_ack, 0);
    tick(); tick(); tick(); #1;
    chk("in_wait4_pc", pc_write, 0);
    tick(); in_valid = 1; #1;
    chk("in_ack", in_ack, 1);
    chk("in_ack_pc", pc_write, 1);
    chk("in_ack_idex_f", idex_flush, 0);
    chk("in_stall", stall_count, 6);
    tick(); id_in = 0; in_valid = 0; #1;
    chk("in_ack_once", in_ack, 0);
    chk("in_stall_hold", stall_count, 6);
    tick(); id_halt = 1; ex_branch_taken = 1; #1;
    chk("br_halt_ifid_f", ifid_flush, 1);
    chk("br_halt_idex_f", idex_flush, 1);
    chk("br_halt_pc", pc_write, 1);
    tick(); id_halt = 0; ex_branch_taken = 0; #1;
    chk("br_halt_run_pc", pc_write, 1);
    chk("br_halt_halted", halted, 0);
    id_jump = 1; #1;
    chk("jump_ifid_f", ifid_flush, 1);
    chk("jump_idex_f", idex_flush, 0);
    chk("jump_pc", pc_write, 1);
    tick(); id_jump = 0; id_jump_r = 1; #1;
    chk("jr_ifid_f", ifid_flush, 1);
    chk("jr_pc", pc_write, 1);
    tick(); id_jump_r = 0; #1;
    chk("jr_done_ifid_f", ifid_flush, 0);
    chk("jump_stall", stall_count, 6);
    id_in = 1; #1;
    chk("in2_wait_pc", pc_write, 0);
    tick(); ex_branch_taken = 1; in_valid = 1; #1;
    chk("br_in_ack", in_ack, 0);
    chk("br_in_ifid_f", ifid_flush, 1);
    chk("br_in_pc", pc_write, 1);
    tick(); ex_branch_taken = 0; id_in = 0; in_valid = 0; #1;
    chk("br_in_run_pc", pc_write, 1);
    chk("br_in_stall", stall_count, 7);
    id_halt = 1; #1;
    chk("halt_acc_pc", pc_write, 0);
    chk("halt_acc_idex_f", idex_flush, 1);
    tick(); id_halt = 0; ex_branch_taken = 1; #1;
    chk("drain1_pc", pc_write, 0);
    chk("drain1_ifid_f", ifid_flush, 0);
    chk("drain1_halted", halted, 0);
    tick(); #1;
    chk("drain2_halted", halted, 0);
    tick(); #1;
    chk("drain3_halted", halted, 0);
    tick(); ex_branch_taken = 0; #1;
    chk("halted_rise", halted, 1);
    chk("halted_pc", pc_write, 0);
    chk("halted_stall", stall_count, 11);
    tick(); tick(); #1;
    chk("halted_frozen_pc", pc_write, 0);
    chk("halted_frozen_stall", stall_count, 11);
    chk("halted_hold", halted, 1);
    rst_n = 0; #1;
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_stall", stall_count, 0);
    chk("mid_rst_ifid_f", ifid_flush, 1);
    tick(); rst_n = 1; #1;
    chk("post_rst_pc", pc_write, 1);
    chk("post_rst_halted", halted, 0);
    ex_mem_read = 1; ex_rd = 2; id_rs = 2;
    repeat (70000) tick();
    #1;
    chk("sat_stall", stall_count, 16'hFFFF);
    tick(); #1;
    chk("sat_hold", stall_count, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Hazard and sequencing controller for the 5-stage pipelined MIPS core. It takes the decoded control bits of the instruction in ID (HALT, IN, Jump, Jump_R) plus EX-stage load and branch-resolution status, and drives PC / IF-ID write enables, pipeline flushes and the IN-port handshake. It owns the halt drain sequence and a saturating stall-cycle counter. It sits between the main controller and the pipeline registers.

## Interface
- REG_AW, 3: register-address width.
- DRAIN_CYCLES, 3: cycles allowed for EX/MEM/WB to retire after HALT is accepted; must be 1..7.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_halt, id_in, id_jump, id_jump_r  in  1 each  decoded control bits of the instruction in ID.
- id_rs, id_rt  in  REG_AW  ID source registers.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  EX instruction is LW.
- ex_rd  in  REG_AW  EX destination register.
- ex_branch_taken  in  1  BEQ/BNE in EX resolved taken.
- in_valid  in  1  external IN port holds valid data.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads a bubble (all write/branch/jump/halt controls 0).
- in_ack  out  1  IN data consumed this cycle.
- halted  out  1  core stopped; registered.
- stall_count  out  16  saturating count of stall cycles; registered.

## Operation
- States: RUN, IN_WAIT, DRAIN, HALTED. Reset state RUN.
- Term load_use = ex_mem_read & (ex_rd == id_rs | (id_uses_rt & ex_rd == id_rt)).
- Priority per cycle, highest first:
  - ex_branch_taken in RUN or IN_WAIT: ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1. The ID instruction is squashed, including HALT/IN. Next state RUN, in_ack=0.
  - load_use: pc_write=0, ifid_write=0, idex_flush=1, in_ack=0. State unchanged.
  - id_halt in RUN: pc_write=0, ifid_write=0, idex_flush=1. Load drain counter with DRAIN_CYCLES-1. Next state DRAIN.
  - id_in & !in_valid: stall as for load_use. Next state IN_WAIT.
  - id_in & in_valid: in_ack=1 for exactly this cycle, no stall. Next state RUN.
  - id_jump | id_jump_r: ifid_flush=1, pc_write=1, ifid_write=1.
  - Otherwise: pc_write=1, ifid_write=1, no flush.
- IN_WAIT holds the stall until in_valid=1. The exit cycle follows the id_in & in_valid rule.
- DRAIN: pc_write=0, ifid_write=0, idex_flush=1. ex_branch_taken is ignored in DRAIN. The counter decrements each cycle; when it reads 0 the next state is HALTED.
- HALTED: same outputs as DRAIN, halted=1. Only rst_n leaves HALTED.
- stall_count increments on every cycle with pc_write=0 outside HALTED, and saturates at 16'hFFFF.

## Timing
- All enable and flush outputs are combinational from state and inputs. halted and stall_count are registered.
- While rst_n=0, outputs are forced to: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, in_ack=0, halted=0, stall_count=0.
- Reset deasserted mid-DRAIN or mid-IN_WAIT: the next cycle is RUN with normal fetch.
- Load-use costs exactly 1 stall cycle, because the LW leaves EX next cycle.
- Jump costs 1 bubble. A taken branch costs 2 bubbles.
- HALT accepted at edge N: halted rises at edge N+DRAIN_CYCLES and pc_write stays 0 from cycle N onward.
- in_ack is never asserted in the same cycle as a flush or a stall of the IN instruction.

## Test plan
- LW r2 in EX, ID instruction reads rs=r2 → one cycle with pc_write=0, idex_flush=1. The next cycle has pc_write=1. stall_count=1.
- ID=IN, in_valid low for 4 cycles then high → 4 stall cycles in IN_WAIT, then in_ack=1 for one cycle. stall_count=4.
- ex_branch_taken=1 while ID holds HALT → ifid_flush=idex_flush=1, state stays RUN, halted stays 0.
- HALT in ID with DRAIN_CYCLES=3 → halted=1 exactly 3 edges after acceptance. pc_write stays 0 and outputs stay frozen until rst_n pulses low, after which halted=0 and pc_write=1.
- Jump in ID, then Jump_R in ID → each gives ifid_flush=1 for one cycle and pc_write=1; stall_count is unchanged.
- Force 70000 load-use stalls → stall_count saturates at 16'hFFFF.
